// File: rtl/maxmin_pkg.sv
// maxmin_pkg: shared constants for the per-frame max/min/range unit.
// Holds the result-select codes and the frame sequencer state encoding.
package maxmin_pkg;

  // Result select codes on the mode input (3 is an alias of range)
  localparam logic [1:0] MODE_MAX   = 2'd0;
  localparam logic [1:0] MODE_MIN   = 2'd1;
  localparam logic [1:0] MODE_RANGE = 2'd2;

  // Frame sequencer states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

endpackage

// File: rtl/maxmin_frame_if.sv
// maxmin_frame_if: sample stream in, per-frame statistics out.
// Optional index outputs appear only when MAXMIN_FRAME_INDEX_EN is defined.
interface maxmin_frame_if #(
  parameter int W   = 16,
  parameter int LEN = 16
);

  logic           din_valid;
  logic [W-1:0]   din;
  logic [1:0]     mode;
  logic [W:0]     dout;
  logic [W-1:0]   max_o;
  logic [W-1:0]   min_o;
  logic           rdy;
`ifdef MAXMIN_FRAME_INDEX_EN
  logic [$clog2(LEN)-1:0] idx_max;
  logic [$clog2(LEN)-1:0] idx_min;
`endif

  // Sample source / result consumer side
  modport master (
    output din_valid, din, mode,
`ifdef MAXMIN_FRAME_INDEX_EN
    input  idx_max, idx_min,
`endif
    input  dout, max_o, min_o, rdy
  );

  // Statistics unit side
  modport slave (
    input  din_valid, din, mode,
`ifdef MAXMIN_FRAME_INDEX_EN
    output idx_max, idx_min,
`endif
    output dout, max_o, min_o, rdy
  );

endinterface

// File: rtl/maxmin_cmp.sv
// maxmin_cmp: combinational compare-select of one sample against the
// running extrema. Strict compares, so ties keep the earlier extremum.
module maxmin_cmp #(
  parameter int W      = 16,
  parameter bit SIGNED = 1'b1
) (
  input  logic [W-1:0] cur_max,
  input  logic [W-1:0] cur_min,
  input  logic [W-1:0] din,
  output logic [W-1:0] new_max,
  output logic [W-1:0] new_min,
  output logic         upd_max,
  output logic         upd_min
);

  generate
    if (SIGNED) begin : g_signed
      assign upd_max = $signed(din) > $signed(cur_max);
      assign upd_min = $signed(din) < $signed(cur_min);
    end else begin : g_unsigned
      assign upd_max = din > cur_max;
      assign upd_min = din < cur_min;
    end
  endgenerate

  assign new_max = upd_max ? din : cur_max;
  assign new_min = upd_min ? din : cur_min;

endmodule

// File: rtl/maxmin_frame.sv
// maxmin_frame: splits a valid-qualified sample stream into frames of LEN
// samples and reports max, min and the mode-selected result (max, min or
// range) with a one-cycle rdy pulse. No backpressure, no bubbles between
// frames. Define MAXMIN_FRAME_INDEX_EN to add first-occurrence index outputs.
module maxmin_frame
  import maxmin_pkg::*;
#(
  parameter int W      = 16,
  parameter int LEN    = 16,
  parameter bit SIGNED = 1'b1
) (
  input  logic clk,
  input  logic rst,
  maxmin_frame_if.slave bus
);

  localparam int            CW   = $clog2(LEN);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    mode_q;
  logic [W-1:0]  cur_max_q;
  logic [W-1:0]  cur_min_q;
  logic [W-1:0]  max_q;
  logic [W-1:0]  min_q;
  logic [W:0]    dout_q;
  logic          rdy_q;

  logic [W-1:0]  new_max;
  logic [W-1:0]  new_min;
  logic          upd_max;
  logic          upd_min;
  logic [W:0]    max_ext;
  logic [W:0]    min_ext;
  logic [W:0]    dout_d;

  maxmin_cmp #(
    .W      (W),
    .SIGNED (SIGNED)
  ) u_cmp (
    .cur_max (cur_max_q),
    .cur_min (cur_min_q),
    .din     (bus.din),
    .new_max (new_max),
    .new_min (new_min),
    .upd_max (upd_max),
    .upd_min (upd_min)
  );

  // Result for the frame being closed, using the mode latched at its first sample
  always_comb begin
    max_ext = SIGNED ? {new_max[W-1], new_max} : {1'b0, new_max};
    min_ext = SIGNED ? {new_min[W-1], new_min} : {1'b0, new_min};
    dout_d  = max_ext - min_ext;
    case (mode_q)
      MODE_MAX: dout_d = max_ext;
      MODE_MIN: dout_d = min_ext;
      default:  dout_d = max_ext - min_ext;
    endcase
  end

  // Frame sequencer: seed on the first sample, accumulate, close on the LEN-th
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mode_q    <= MODE_MAX;
      cur_max_q <= '0;
      cur_min_q <= '0;
      max_q     <= '0;
      min_q     <= '0;
      dout_q    <= '0;
      rdy_q     <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (bus.din_valid) begin
        case (state_q)
          ST_IDLE: begin
            cur_max_q <= bus.din;
            cur_min_q <= bus.din;
            mode_q    <= bus.mode;
            cnt_q     <= CW'(1);
            state_q   <= ST_ACC;
          end
          ST_ACC: begin
            if (upd_max) cur_max_q <= bus.din;
            if (upd_min) cur_min_q <= bus.din;
            if (cnt_q == LAST) begin
              max_q   <= new_max;
              min_q   <= new_min;
              dout_q  <= dout_d;
              rdy_q   <= 1'b1;
              cnt_q   <= '0;
              state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.dout  = dout_q;
  assign bus.max_o = max_q;
  assign bus.min_o = min_q;
  assign bus.rdy   = rdy_q;

`ifdef MAXMIN_FRAME_INDEX_EN
  logic [CW-1:0] run_max_q;
  logic [CW-1:0] run_min_q;
  logic [CW-1:0] idx_max_q;
  logic [CW-1:0] idx_min_q;
  logic [CW-1:0] idx_max_d;
  logic [CW-1:0] idx_min_d;

  // Position of the running extrema after the current sample (cnt is its in-frame index)
  always_comb begin
    idx_max_d = upd_max ? cnt_q : run_max_q;
    idx_min_d = upd_min ? cnt_q : run_min_q;
  end

  // Track first-occurrence positions and publish them with the frame results
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_max_q <= '0;
      run_min_q <= '0;
      idx_max_q <= '0;
      idx_min_q <= '0;
    end else if (bus.din_valid) begin
      if (state_q == ST_IDLE) begin
        run_max_q <= '0;
        run_min_q <= '0;
      end else begin
        run_max_q <= idx_max_d;
        run_min_q <= idx_min_d;
        if (cnt_q == LAST) begin
          idx_max_q <= idx_max_d;
          idx_min_q <= idx_min_d;
        end
      end
    end
  end

  assign bus.idx_max = idx_max_q;
  assign bus.idx_min = idx_min_q;
`endif

endmodule

// File: tb/tb_maxmin_frame.sv
// tb_maxmin_frame: two instances (16-bit/LEN 16/signed and 8-bit/LEN 4/unsigned)
// exercised by hand sequences, a vector table and random traffic. A frame-level
// reference model predicts every rdy pulse and its results.
module tb_maxmin_frame;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  maxmin_frame_if #(.W(16), .LEN(16)) ifa ();
  maxmin_frame_if #(.W(8),  .LEN(4))  ifb ();

  maxmin_frame #(.W(16), .LEN(16), .SIGNED(1'b1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  maxmin_frame #(.W(8), .LEN(4), .SIGNED(1'b0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  typedef struct {
    longint mx;
    longint mn;
    longint dv;
    int     imx;
    int     imn;
  } exp_t;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic longint msk(longint v, int w);
    return v & ((longint'(1) << w) - 1);
  endfunction

  // Frame reference: interpret raw samples as numbers, take first-occurrence extrema
  function automatic exp_t ref_frame(input longint s[$], input int w, input bit sgn,
                                     input logic [1:0] md);
    exp_t   e;
    longint v;
    longint mx = 0;
    longint mn = 0;
    e.imx = 0;
    e.imn = 0;
    for (int i = 0; i < s.size(); i++) begin
      v = s[i];
      if (sgn && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
      if (i == 0 || v > mx) begin mx = v; e.imx = i; end
      if (i == 0 || v < mn) begin mn = v; e.imn = i; end
    end
    e.mx = msk(mx, w);
    e.mn = msk(mn, w);
    if (md == 2'd0)      e.dv = msk(mx, w + 1);
    else if (md == 2'd1) e.dv = msk(mn, w + 1);
    else                 e.dv = msk(mx - mn, w + 1);
    return e;
  endfunction

  // ---------------- reference model and monitor, instance A ----------------
  longint     buf_a[$];
  logic [1:0] fmode_a;
  exp_t       exp_a[$];
  exp_t       ea;
  int         frames_a = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_a.delete();
      exp_a.delete();
    end else if (ifa.din_valid) begin
      if (buf_a.size() == 0) fmode_a = ifa.mode;
      buf_a.push_back(longint'(ifa.din));
      if (buf_a.size() == 16) begin
        exp_a.push_back(ref_frame(buf_a, 16, 1'b1, fmode_a));
        buf_a.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("a_rdy_model", 64'(ifa.rdy), 64'(exp_a.size() != 0));
      if (exp_a.size() != 0) begin
        ea = exp_a.pop_front();
        if (ifa.rdy) begin
          frames_a++;
          chk("a_max_model", 64'(ifa.max_o), ea.mx);
          chk("a_min_model", 64'(ifa.min_o), ea.mn);
          chk("a_dout_model", 64'(ifa.dout), ea.dv);
`ifdef MAXMIN_FRAME_INDEX_EN
          chk("a_imax_model", 64'(ifa.idx_max), 64'(ea.imx));
          chk("a_imin_model", 64'(ifa.idx_min), 64'(ea.imn));
`endif
          $display("A frame %0d max=%0h min=%0h dout=%0h", frames_a, ifa.max_o, ifa.min_o, ifa.dout);
        end
      end
    end
  end

  // ---------------- reference model and monitor, instance B ----------------
  longint     buf_b[$];
  logic [1:0] fmode_b;
  exp_t       exp_b[$];
  exp_t       eb;
  int         frames_b = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_b.delete();
      exp_b.delete();
    end else if (ifb.din_valid) begin
      if (buf_b.size() == 0) fmode_b = ifb.mode;
      buf_b.push_back(longint'(ifb.din));
      if (buf_b.size() == 4) begin
        exp_b.push_back(ref_frame(buf_b, 8, 1'b0, fmode_b));
        buf_b.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("b_rdy_model", 64'(ifb.rdy), 64'(exp_b.size() != 0));
      if (exp_b.size() != 0) begin
        eb = exp_b.pop_front();
        if (ifb.rdy) begin
          frames_b++;
          chk("b_max_model", 64'(ifb.max_o), eb.mx);
          chk("b_min_model", 64'(ifb.min_o), eb.mn);
          chk("b_dout_model", 64'(ifb.dout), eb.dv);
`ifdef MAXMIN_FRAME_INDEX_EN
          chk("b_imax_model", 64'(ifb.idx_max), 64'(eb.imx));
          chk("b_imin_model", 64'(ifb.idx_min), 64'(eb.imn));
`endif
          $display("B frame %0d max=%0h min=%0h dout=%0h", frames_b, ifb.max_o, ifb.min_o, ifb.dout);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic step_a(input logic v, input logic [15:0] d, input logic [1:0] m);
    ifa.din_valid = v;
    ifa.din       = d;
    ifa.mode      = m;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic v, input logic [7:0] d, input logic [1:0] m);
    ifb.din_valid = v;
    ifb.din       = d;
    ifb.mode      = m;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] alt(int i);
    return (i % 2 == 1) ? 16'(i) : 16'(-i);
  endfunction

  // ---------------- vector table for instance B ----------------
  typedef struct {
    logic [31:0] s;      // first sample in the top byte
    logic [1:0]  md;
    logic [7:0]  emax;
    logic [7:0]  emin;
    logic [8:0]  edout;
    int          eimx;
    int          eimn;
  } vec_t;

  vec_t vecs[7];
  int   seen;

  initial begin
    vecs[0] = '{32'hFF01807F, 2'd2, 8'hFF, 8'h01, 9'd254,  0, 1};
    vecs[1] = '{32'h05090209, 2'd0, 8'h09, 8'h02, 9'h009,  1, 2};
    vecs[2] = '{32'h05090209, 2'd1, 8'h09, 8'h02, 9'h002,  1, 2};
    vecs[3] = '{32'h00000000, 2'd3, 8'h00, 8'h00, 9'h000,  0, 0};
    vecs[4] = '{32'h10203040, 2'd0, 8'h40, 8'h10, 9'h040,  3, 0};
    vecs[5] = '{32'h80807F81, 2'd2, 8'h81, 8'h7F, 9'h002,  3, 2};
    vecs[6] = '{32'h7FFF00FF, 2'd1, 8'hFF, 8'h00, 9'h000,  1, 2};

    ifa.din_valid = 1'b0; ifa.din = '0; ifa.mode = 2'd0;
    ifb.din_valid = 1'b0; ifb.din = '0; ifb.mode = 2'd0;

    // Reset state
    #3 rst = 1'b0;
    #10;
    chk("rst_a_rdy",  64'(ifa.rdy),   64'd0);
    chk("rst_a_dout", 64'(ifa.dout),  64'd0);
    chk("rst_a_max",  64'(ifa.max_o), 64'd0);
    chk("rst_a_min",  64'(ifa.min_o), 64'd0);
    chk("rst_b_rdy",  64'(ifb.rdy),   64'd0);
    chk("rst_b_dout", 64'(ifb.dout),  64'd0);
`ifdef MAXMIN_FRAME_INDEX_EN
    chk("rst_b_imax", 64'(ifb.idx_max), 64'd0);
    chk("rst_b_imin", 64'(ifb.idx_min), 64'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b1;
    step_a(1'b0, 16'd0, 2'd0);

    // A: alternating 1,-2,...,-16 with range select
    for (int i = 1; i <= 16; i++) begin
      step_a(1'b1, alt(i), 2'd2);
      if (i == 15) chk("a1_rdy_early", 64'(ifa.rdy), 64'd0);
    end
    chk("a1_rdy",  64'(ifa.rdy),   64'd1);
    chk("a1_max",  64'(ifa.max_o), 64'h000F);
    chk("a1_min",  64'(ifa.min_o), 64'hFFF0);
    chk("a1_dout", 64'(ifa.dout),  64'd31);
    step_a(1'b0, 16'd0, 2'd0);
    chk("a1_rdy_drop", 64'(ifa.rdy),   64'd0);
    chk("a1_hold_max", 64'(ifa.max_o), 64'h000F);

    // A: two back-to-back frames; mode flips to min mid-way through the first
    for (int i = 1; i <= 32; i++) begin
      step_a(1'b1, alt(((i - 1) % 16) + 1), (i <= 8) ? 2'd0 : 2'd1);
      if (i == 16) begin
        chk("a2_rdy1",  64'(ifa.rdy),  64'd1);
        chk("a2_dout1", 64'(ifa.dout), 64'h0000F);
      end
      if (i == 17) chk("a2_rdy_gap", 64'(ifa.rdy), 64'd0);
      if (i == 17) chk("a2_hold",    64'(ifa.dout), 64'h0000F);
    end
    chk("a2_rdy2",  64'(ifa.rdy),   64'd1);
    chk("a2_dout2", 64'(ifa.dout),  64'h1FFF0);
    chk("a2_min2",  64'(ifa.min_o), 64'hFFF0);
    step_a(1'b0, 16'd0, 2'd0);

    // A: reset after 7 samples discards the partial frame
    for (int i = 1; i <= 7; i++) step_a(1'b1, 16'(100 + i), 2'd2);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    seen = 0;
    for (int i = 1; i <= 16; i++) begin
      step_a(1'b1, 16'd3, 2'd2);
      if (i < 16) seen += int'(ifa.rdy);
    end
    chk("a3_no_rdy_partial", 64'(seen),       64'd0);
    chk("a3_rdy",            64'(ifa.rdy),    64'd1);
    chk("a3_max",            64'(ifa.max_o),  64'd3);
    chk("a3_min",            64'(ifa.min_o),  64'd3);
    chk("a3_dout",           64'(ifa.dout),   64'd0);
    step_a(1'b0, 16'd0, 2'd0);

    // B: vector table, continuous valid
    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < 4; k++) begin
        step_b(1'b1, vecs[v].s[31 - 8 * k -: 8], vecs[v].md);
        if (k == 2) chk($sformatf("b_tab%0d_rdy_early", v), 64'(ifb.rdy), 64'd0);
      end
      chk($sformatf("b_tab%0d_rdy", v),  64'(ifb.rdy),   64'd1);
      chk($sformatf("b_tab%0d_max", v),  64'(ifb.max_o), 64'(vecs[v].emax));
      chk($sformatf("b_tab%0d_min", v),  64'(ifb.min_o), 64'(vecs[v].emin));
      chk($sformatf("b_tab%0d_dout", v), 64'(ifb.dout),  64'(vecs[v].edout));
`ifdef MAXMIN_FRAME_INDEX_EN
      chk($sformatf("b_tab%0d_imax", v), 64'(ifb.idx_max), 64'(vecs[v].eimx));
      chk($sformatf("b_tab%0d_imin", v), 64'(ifb.idx_min), 64'(vecs[v].eimn));
`endif
    end
    step_b(1'b0, 8'd0, 2'd0);

    // B: gaps in the stream are ignored
    step_b(1'b1, 8'd5, 2'd0);
    step_b(1'b0, 8'd77, 2'd0);
    step_b(1'b0, 8'd200, 2'd0);
    step_b(1'b1, 8'd9, 2'd0);
    step_b(1'b1, 8'd2, 2'd0);
    chk("b_gap_rdy_early", 64'(ifb.rdy), 64'd0);
    step_b(1'b1, 8'd9, 2'd0);
    chk("b_gap_rdy",  64'(ifb.rdy),   64'd1);
    chk("b_gap_max",  64'(ifb.max_o), 64'd9);
    chk("b_gap_min",  64'(ifb.min_o), 64'd2);
    chk("b_gap_dout", 64'(ifb.dout),  64'd9);
`ifdef MAXMIN_FRAME_INDEX_EN
    chk("b_gap_imax", 64'(ifb.idx_max), 64'd1);
    chk("b_gap_imin", 64'(ifb.idx_min), 64'd2);
`endif
    step_b(1'b0, 8'd0, 2'd0);

    // Random traffic on both instances, checked by the reference models
    for (int c = 0; c < 1200; c++) begin
      ifa.din_valid = ($urandom_range(0, 9) < 7);
      ifa.din       = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 3));
      ifa.mode      = 2'($urandom_range(0, 3));
      ifb.din_valid = ($urandom_range(0, 9) < 6);
      ifb.din       = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(250, 255));
      ifb.mode      = 2'($urandom_range(0, 3));
      @(posedge clk);
      #1;
    end
    ifa.din_valid = 1'b0;
    ifb.din_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maxmin_frame.md
Name: maxmin_frame

Overview:
- Streaming, parametrised frame statistics unit. Generalises the fixed 16-sample max/min block.
- Consumes a stream of samples qualified by din_valid and partitions it into non-overlapping frames of LEN samples.
- Per frame, computes maximum, minimum and range (max-min). Presents the mode-selected result on dout with a one-cycle rdy pulse.
- Sits between a sample source (ADC/test feeder) and any consumer of per-frame extrema; full throughput, no backpressure.

Parameters:
- W, 16, sample width in bits.
- LEN, 16, samples per frame; must be >= 2.
- SIGNED, 1, 1 = two's-complement compare, 0 = unsigned compare.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low.
- din_valid  input  1  sample qualifier; one sample accepted per cycle while high.
- din  input  W  sample.
- mode  input  2  result select: 0 = max, 1 = min, 2 = range, 3 = range (reserved alias).
- dout  output  W+1  selected result.
- max_o  output  W  frame maximum.
- min_o  output  W  frame minimum.
- rdy  output  1  one-cycle pulse; dout, max_o and min_o are valid for the frame just completed.

Behaviour:
- Reset values (rst low, async): dout=0, max_o=0, min_o=0, rdy=0, cnt=0, FSM=IDLE.
- Sign handling:
  - max/min results are sign-extended to W+1 bits on dout when SIGNED=1, and zero-extended when SIGNED=0.
  - range is always unsigned W+1 bits and cannot overflow.
- Sample counter cnt, width $clog2(LEN):
  - Increments on each accepted sample.
  - Wraps to 0 after sample LEN-1.
- FSM states and transitions:
  - IDLE: cnt=0. An accepted sample loads cur_max=cur_min=din, latches mode into mode_q, and moves to ACC.
  - ACC: each accepted sample updates cur_max and cur_min by the active compare.
    - On the accepted sample with cnt==LEN-1: results are registered at that edge, rdy=1 during the following cycle, and state returns to IDLE.
  - A gap cycle (din_valid=0) holds all state; there is no timeout.
- Latency: rdy is high in the cycle after the edge that accepted the LEN-th sample.
- Throughput: a new frame's first sample may be accepted in the very cycle rdy is high, so zero bubbles between frames. Outputs from frame k hold until frame k+1's rdy.
- Ties: equal values do not change the extremum (first occurrence wins; relevant to the optional feature).
- mode is sampled only at the first sample of a frame; mid-frame changes take effect next frame.
- Reset mid-frame: the partial frame is discarded, no rdy is issued, and the next accepted sample starts a fresh frame.
- rdy is never high for two consecutive cycles unless LEN samples arrived in between. Since LEN>=2, it is never high on consecutive cycles.

Optional Feature:
- Macro MAXMIN_FRAME_INDEX_EN.
- Defined:
  - Adds outputs idx_max and idx_min, each $clog2(LEN) bits.
  - Each holds the in-frame position (0..LEN-1) of the first occurrence of the max/min.
  - Registered alongside max_o/min_o, reset to 0.
- Undefined: the ports and index registers are absent; all other behaviour is identical.

Decomposition:
- Package maxmin_pkg holds:
  - Mode constants MODE_MAX=2'd0, MODE_MIN=2'd1, MODE_RANGE=2'd2.
  - FSM state encoding ST_IDLE, ST_ACC.
- Sub-module maxmin_cmp (params W, SIGNED):
  - Combinational compare-select.
  - Inputs: cur_max, cur_min, din.
  - Outputs: new_max, new_min, upd_max, upd_min (the upd flags drive the index registers).
  - The top level instantiates it once.

Test Plan:
- LEN=16, SIGNED=1, mode=2, samples i*(-1)^(i-1) for i=1..16 (1,-2,3,...,-16), din_valid continuous -> one rdy pulse the cycle after sample 16; max_o=15, min_o=-16, dout=31.
- Same stream with mode=0 then mode=1 on two back-to-back frames (32 consecutive valid cycles) -> rdy at cycles 17 and 33, with no bubble; dout=15, then dout=-16 (17'h1FFF0).
- SIGNED=0, W=8, LEN=4, samples 8'hFF,8'h01,8'h80,8'h7F, mode=2 -> max_o=255, min_o=1, dout=254.
- LEN=4, mode=0, samples 5,_,_,9,2,9 with din_valid low on the "_" cycles -> gaps ignored; first 4 valid samples 5,9,2,9 give max_o=9. Under MAXMIN_FRAME_INDEX_EN, idx_max=1 and idx_min=2.
- rst pulsed low after 7 of 16 samples, then 16 samples of value 3 -> no rdy for the partial frame; a single rdy with max_o=min_o=3, dout=0 (mode=2).
- Toggle mode mid-frame from 0 to 1 -> the completed frame reports max; the next frame reports min.
